// File: rtl/fft_stream_core_if.sv
// Sample-in / bin-out streaming bundle for fft_stream_core.
// The core takes the slave view; the sample source and bin sink together take the master view.
interface fft_stream_core_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 21,
    parameter int IDX_W = 3
);
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic signed [IN_W-1:0]  s_re_i;
    logic signed [IN_W-1:0]  s_im_i;
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic signed [OUT_W-1:0] m_re_o;
    logic signed [OUT_W-1:0] m_im_o;
    logic [IDX_W-1:0]        m_idx_o;
    logic                    m_last_o;

    modport slave (
        input  s_valid_i, s_re_i, s_im_i, m_ready_i,
        output s_ready_o, m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o
    );

    modport master (
        output s_valid_i, s_re_i, s_im_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o
    );
endinterface

// File: rtl/fft_stream_core.sv
// Iterative in-place radix-2 DIT FFT, one shared two-cycle butterfly, streaming load/unload.
// Define FFT_INVERSE_EN to add inv_i (per-frame conjugate-twiddle inverse transform, unscaled).
module fft_stream_core #(
    parameter int N    = 8,
    parameter int IN_W = 16,
    parameter int TW_W = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef FFT_INVERSE_EN
    input  logic inv_i,
`endif
    output logic busy_o,
    fft_stream_core_if.slave io
);
    localparam int     LOG2N  = $clog2(N);
    localparam int     OUT_W  = IN_W + LOG2N + 2;
    localparam int     HALF   = N / 2;
    localparam int     QUART  = N / 4;
    localparam int     ROM_AW = $clog2(QUART + 1);
    localparam int     PW     = OUT_W + TW_W + 1;
    localparam real    PI     = 3.14159265358979323846;
    localparam longint TW_MAX = (longint'(1) <<< (TW_W - 1)) - 1;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t                  state;
    logic [LOG2N-1:0]        cnt;
    logic [LOG2N-2:0]        bf_idx;
    logic [LOG2N-1:0]        stage;
    logic                    phase;
    logic                    inv_q;
    logic                    s_ready_q, m_valid_q, m_last_q, busy_q;
    logic [LOG2N-1:0]        m_idx_q;
    logic signed [OUT_W-1:0] m_re_q, m_im_q;

    logic signed [OUT_W-1:0] mem_re [N];
    logic signed [OUT_W-1:0] mem_im [N];
    logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW_W-1:0]  cos_rom [QUART+1];
    logic signed [TW_W-1:0]  sin_rom [QUART+1];

    // First quadrant only; the second quadrant is folded onto it in the twiddle select.
    for (genvar i = 0; i <= QUART; i++) begin : g_tw
        localparam real    ANG   = 2.0 * PI * i / N;
        localparam longint COS_Q = longint'($rtoi($cos(ANG) * (TW_MAX + 1) + 0.5));
        localparam longint SIN_Q = longint'($rtoi($sin(ANG) * (TW_MAX + 1) + 0.5));
        assign cos_rom[i] = TW_W'(COS_Q > TW_MAX ? TW_MAX : COS_Q);
        assign sin_rom[i] = TW_W'(SIN_Q > TW_MAX ? TW_MAX : SIN_Q);
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    logic                    s_fire;
    logic [LOG2N-1:0]        span, pos, grp, idx_a, idx_b, tw_k, nxt_idx;
    logic [ROM_AW-1:0]       rom_idx;
    logic signed [TW_W-1:0]  tw_c, tw_s;
    logic signed [PW-1:0]    p_re, p_im;
    logic signed [OUT_W-1:0] t_re, t_im;

    assign s_fire  = io.s_valid_i && s_ready_q;
    assign nxt_idx = m_idx_q + LOG2N'(1);

    always_comb begin
        span  = LOG2N'(1) << stage;
        pos   = {1'b0, bf_idx} & (span - LOG2N'(1));
        grp   = {1'b0, bf_idx} >> stage;
        idx_a = (grp << (stage + LOG2N'(1))) | pos;
        idx_b = idx_a | span;
        tw_k  = pos << (LOG2N'(LOG2N - 1) - stage);
    end

    // NOTE: every output of this block is assigned before any branch, so no latch can form.
    always_comb begin
        rom_idx = (tw_k <= LOG2N'(QUART)) ? ROM_AW'(tw_k) : ROM_AW'(LOG2N'(HALF) - tw_k);
        tw_c    = (tw_k <= LOG2N'(QUART)) ? cos_rom[rom_idx] : -cos_rom[rom_idx];
        tw_s    = inv_q ? -sin_rom[rom_idx] : sin_rom[rom_idx];
        p_re    = PW'(b_re) * PW'(tw_c) + PW'(b_im) * PW'(tw_s);
        p_im    = PW'(b_im) * PW'(tw_c) - PW'(b_re) * PW'(tw_s);
        t_re    = OUT_W'((p_re + RND) >>> (TW_W - 1));
        t_im    = OUT_W'((p_im + RND) >>> (TW_W - 1));
        if (tw_k == '0) begin
            t_re = b_re;
            t_im = b_im;
        end else if (tw_k == LOG2N'(QUART)) begin
            t_re = inv_q ? -b_im : b_im;
            t_im = inv_q ? b_re : -b_re;
        end
    end

    // NOTE: the frame buffer has no reset; every entry is rewritten by LOAD before it is read.
    always_ff @(posedge clk_i) begin
        if (state == S_LOAD && s_fire) begin
            mem_re[bitrev(cnt)] <= OUT_W'(io.s_re_i);
            mem_im[bitrev(cnt)] <= OUT_W'(io.s_im_i);
        end else if (state == S_COMPUTE) begin
            if (!phase) begin
                a_re <= mem_re[idx_a];
                a_im <= mem_im[idx_a];
                b_re <= mem_re[idx_b];
                b_im <= mem_im[idx_b];
            end else begin
                mem_re[idx_a] <= a_re + t_re;
                mem_im[idx_a] <= a_im + t_im;
                mem_re[idx_b] <= a_re - t_re;
                mem_im[idx_b] <= a_im - t_im;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_LOAD;
            cnt       <= '0;
            bf_idx    <= '0;
            stage     <= '0;
            phase     <= 1'b0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_idx_q   <= '0;
            m_re_q    <= '0;
            m_im_q    <= '0;
            busy_q    <= 1'b0;
`ifdef FFT_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: if (s_fire) begin
`ifdef FFT_INVERSE_EN
                    if (cnt == '0) inv_q <= inv_i;
`endif
                    if (cnt == LOG2N'(N - 1)) begin
                        cnt       <= '0;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= S_COMPUTE;
                    end else begin
                        cnt <= cnt + LOG2N'(1);
                    end
                end
                S_COMPUTE: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (bf_idx == '1) begin
                            bf_idx <= '0;
                            if (stage == LOG2N'(LOG2N - 1)) begin
                                stage  <= '0;
                                busy_q <= 1'b0;
                                state  <= S_UNLOAD;
                            end else begin
                                stage <= stage + LOG2N'(1);
                            end
                        end else begin
                            bf_idx <= bf_idx + 1'b1;
                        end
                    end
                end
                S_UNLOAD: begin
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_re_q    <= mem_re[m_idx_q];
                        m_im_q    <= mem_im[m_idx_q];
                        m_last_q  <= (m_idx_q == LOG2N'(N - 1));
                    end else if (io.m_ready_i) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            m_idx_q   <= '0;
                            m_re_q    <= '0;
                            m_im_q    <= '0;
                            s_ready_q <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            m_idx_q  <= nxt_idx;
                            m_re_q   <= mem_re[nxt_idx];
                            m_im_q   <= mem_im[nxt_idx];
                            m_last_q <= (nxt_idx == LOG2N'(N - 1));
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifndef FFT_INVERSE_EN
    assign inv_q = 1'b0;
`endif

    assign io.s_ready_o = s_ready_q;
    assign io.m_valid_o = m_valid_q;
    assign io.m_re_o    = m_re_q;
    assign io.m_im_o    = m_im_q;
    assign io.m_idx_o   = m_idx_q;
    assign io.m_last_o  = m_last_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_fft_stream_core.sv
// Directed bench for fft_stream_core at N=8: DC, impulse, tone, timing/backpressure,
// mid-COMPUTE reset, and the shifted impulse (inverse when FFT_INVERSE_EN is defined).
module tb_fft_stream_core;
    localparam int N     = 8;
    localparam int IN_W  = 16;
    localparam int OUT_W = 21;
    localparam int T6_RE [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    localparam int T6_IM [8] = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic inv   = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    int   vec_re [8];
    int   vec_im [8];
    logic signed [63:0] exp_re [8];
    logic signed [63:0] exp_im [8];

    fft_stream_core_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(3)) io ();

    fft_stream_core #(.N(N), .IN_W(IN_W), .TW_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef FFT_INVERSE_EN
        .inv_i  (inv),
`endif
        .busy_o (busy),
        .io     (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_ready"}, io.s_ready_o, 1);
        check({tag, "_m_valid"}, io.m_valid_o, 0);
        check({tag, "_m_last"},  io.m_last_o, 0);
        check({tag, "_m_idx"},   io.m_idx_o, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_m_re"},    io.m_re_o, 0);
        check({tag, "_m_im"},    io.m_im_o, 0);
    endtask

    // Drives vec_* as one frame; optionally leaves junk on s_valid during COMPUTE and measures latency.
    task automatic send_frame(input bit wait_out, input bit junk);
        int guard;
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            io.s_valid_i = 1'b1;
            io.s_re_i    = 16'(vec_re[n]);
            io.s_im_i    = 16'(vec_im[n]);
            guard = 0;
            while (!io.s_ready_o && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!io.s_ready_o) begin
                check("load_ready", io.s_ready_o, 1);
                io.s_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            if (n == 0) inv = ~inv;
        end
        #1;
        check("compute_busy", busy, 1);
        check("compute_s_ready", io.s_ready_o, 0);
        io.s_valid_i = junk;
        io.s_re_i    = 16'h7fff;
        io.s_im_i    = 16'h7fff;
        if (wait_out) begin
            lat = 0;
            while (!io.m_valid_o && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("latency", lat, 25);
            io.s_valid_i = 1'b0;
        end
    endtask

    task automatic recv_frame(input string tag, input bit stall);
        int guard;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            guard = 0;
            while (!io.m_valid_o && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!io.m_valid_o) begin
                check({tag, "_bin_valid"}, io.m_valid_o, 1);
                io.m_ready_i = 1'b0;
                return;
            end
            check($sformatf("%s_idx%0d", tag, k), io.m_idx_o, k);
            check($sformatf("%s_last%0d", tag, k), io.m_last_o, (k == N - 1));
            check($sformatf("%s_re%0d", tag, k), io.m_re_o, exp_re[k]);
            check($sformatf("%s_im%0d", tag, k), io.m_im_o, exp_im[k]);
            if (stall && k == 3) begin
                io.m_ready_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check({tag, "_stall_valid"}, io.m_valid_o, 1);
                    check({tag, "_stall_idx"},   io.m_idx_o, 3);
                    check({tag, "_stall_last"},  io.m_last_o, 0);
                    check({tag, "_stall_re"},    io.m_re_o, exp_re[3]);
                    check({tag, "_stall_im"},    io.m_im_o, exp_im[3]);
                end
            end
            io.m_ready_i = 1'b1;
            @(posedge clk);
            if (k == N - 1) begin
                #1;
                check({tag, "_ready_after_last"}, io.s_ready_o, 1);
                check({tag, "_valid_after_last"}, io.m_valid_o, 0);
                check({tag, "_re_after_last"},    io.m_re_o, 0);
                io.m_ready_i = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic set_dc;
        for (int i = 0; i < N; i++) begin
            vec_re[i] = 'h2000;
            vec_im[i] = 0;
            exp_re[i] = (i == 0) ? 65536 : 0;
            exp_im[i] = 0;
        end
    endtask

    initial begin
        io.s_valid_i = 1'b0;
        io.s_re_i    = '0;
        io.s_im_i    = '0;
        io.m_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // DC
        set_dc();
        send_frame(1'b1, 1'b0);
        recv_frame("dc", 1'b0);

        // Impulse at x[0]
        for (int i = 0; i < N; i++) begin
            vec_re[i] = (i == 0) ? 'h4000 : 0;
            vec_im[i] = 0;
            exp_re[i] = 16384;
            exp_im[i] = 0;
        end
        send_frame(1'b1, 1'b0);
        recv_frame("imp", 1'b0);

        // Tone at bin 2 with junk s_valid during COMPUTE and a stall at k=3
        for (int i = 0; i < N; i++) begin
            vec_re[i] = (i % 2 == 1) ? 0 : ((i % 4 == 0) ? 'h4000 : -'h4000);
            vec_im[i] = 0;
            exp_re[i] = (i == 2 || i == 6) ? 65536 : 0;
            exp_im[i] = 0;
        end
        send_frame(1'b1, 1'b1);
        recv_frame("tone", 1'b1);

        // Reset around cycle 10 of COMPUTE, then a clean DC frame
        for (int i = 0; i < N; i++) begin
            vec_re[i] = (i == 0) ? 'h4000 : 0;
            vec_im[i] = 0;
        end
        send_frame(1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        set_dc();
        send_frame(1'b1, 1'b0);
        recv_frame("dc2", 1'b0);

        // Impulse at x[1]: inv starts at 1 and flips after the first handshake
        inv = 1'b1;
        for (int i = 0; i < N; i++) begin
            vec_re[i] = (i == 1) ? 'h4000 : 0;
            vec_im[i] = 0;
            exp_re[i] = T6_RE[i];
`ifdef FFT_INVERSE_EN
            exp_im[i] = -T6_IM[i];
`else
            exp_im[i] = T6_IM[i];
`endif
        end
        send_frame(1'b1, 1'b0);
        recv_frame("shift", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
